axil_master_queued: RTL and testbench

AXIL_MASTER_QUEUED -- requirements
Module: axil_master_queued

---
 rtl/axil_pkg.sv | 17 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/axil_master_queued.sv | 166 ++++++++++++++++
 tb/tb_axil_master_queued.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the queued AXI-Lite master: FSM states and AXI response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock request queue; head entry is visible combinationally so the FSM can pop and use it in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  // A full queue refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level_reg == FULL_LVL);
  assign empty = (level_reg == '0);
  assign level = level_reg;
  assign dout  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/axil_master_queued.sv
// AXI-Lite master that queues read/write requests and issues them one at a time, in order.
module axil_master_queued
  import axil_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          STRB_WIDTH = DATA_WIDTH/8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_wen,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [STRB_WIDTH-1:0]          req_wstrb,
  output logic                           rsp_valid,
  output logic                           rsp_wen,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [ADDR_WIDTH-1:0]          m_axil_awaddr,
  output logic [2:0]                     m_axil_awprot,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready,
  output logic [DATA_WIDTH-1:0]          m_axil_wdata,
  output logic [STRB_WIDTH-1:0]          m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready,
  output logic [ADDR_WIDTH-1:0]          m_axil_araddr,
  output logic [2:0]                     m_axil_arprot,
  output logic                           m_axil_arvalid,
  input  logic                           m_axil_arready,
  input  logic [DATA_WIDTH-1:0]          m_axil_rdata,
  input  logic [1:0]                     m_axil_rresp,
  input  logic                           m_axil_rvalid,
  output logic                           m_axil_rready
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

  state_t                  state_reg;
  logic [REQ_W-1:0]        head;
  logic                    head_wen;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH-1:0]   head_wdata;
  logic [STRB_WIDTH-1:0]   head_wstrb;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic                    aw_done;
  logic                    w_done;

  assign req_ready = !fifo_full;
  assign pop       = (state_reg == IDLE) && !fifo_empty;
  assign busy      = (fifo_level != '0) || (state_reg != IDLE);

  assign m_axil_awprot = AXI_PROT;
  assign m_axil_arprot = AXI_PROT;

  assign {head_wen, head_addr, head_wdata, head_wstrb} = head;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (req_valid),
    .pop   (pop),
    .din   ({req_wen, req_addr, req_wdata, req_wstrb}),
    .dout  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A channel counts as done once its valid has dropped or is being accepted this cycle.
  assign aw_done = !m_axil_awvalid || m_axil_awready;
  assign w_done  = !m_axil_wvalid || m_axil_wready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_wen        <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= RESP_OKAY;
      rsp_err        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            if (head_wen) begin
              m_axil_awaddr  <= head_addr;
              m_axil_wdata   <= head_wdata;
              m_axil_wstrb   <= head_wstrb;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state_reg      <= WR_ADDR;
            end else begin
              m_axil_araddr  <= head_addr;
              m_axil_arvalid <= 1'b1;
              state_reg      <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state_reg      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axil_rvalid) begin
            rsp_rdata     <= m_axil_rdata;
            rsp_resp      <= m_axil_rresp;
            rsp_err       <= m_axil_rresp[1];
            rsp_wen       <= 1'b0;
            rsp_valid     <= 1'b1;
            m_axil_rready <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        WR_ADDR: begin
          if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axil_bready <= 1'b1;
            state_reg     <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            rsp_resp      <= m_axil_bresp;
            rsp_err       <= m_axil_bresp[1];
            rsp_wen       <= 1'b1;
            rsp_valid     <= 1'b1;
            m_axil_bready <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_queued.sv
// Directed bench for axil_master_queued with a small latency-configurable AXI-Lite slave model.
module tb_axil_master_queued;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_valid, rsp_wen, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [2:0]    fifo_level;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_awready = 1'b0;
  logic [DW-1:0] m_axil_wdata;
  logic [SW-1:0] m_axil_wstrb;
  logic          m_axil_wvalid, m_axil_wready = 1'b0;
  logic [1:0]    m_axil_bresp = 2'b00;
  logic          m_axil_bvalid = 1'b0, m_axil_bready;
  logic          m_axil_arvalid, m_axil_arready = 1'b0;
  logic [DW-1:0] m_axil_rdata = '0;
  logic [1:0]    m_axil_rresp = 2'b00;
  logic          m_axil_rvalid = 1'b0, m_axil_rready;

  always #5 clk = ~clk;

  axil_master_queued #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .STRB_WIDTH (SW), .FIFO_DEPTH (FD), .AXI_PROT (3'b000)
  ) dut (
    .clk (clk), .rstn (rstn),
    .req_valid (req_valid), .req_ready (req_ready), .req_wen (req_wen),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid), .rsp_wen (rsp_wen), .rsp_rdata (rsp_rdata),
    .rsp_resp (rsp_resp), .rsp_err (rsp_err), .busy (busy), .fifo_level (fifo_level),
    .m_axil_awaddr (m_axil_awaddr), .m_axil_awprot (m_axil_awprot),
    .m_axil_awvalid (m_axil_awvalid), .m_axil_awready (m_axil_awready),
    .m_axil_wdata (m_axil_wdata), .m_axil_wstrb (m_axil_wstrb),
    .m_axil_wvalid (m_axil_wvalid), .m_axil_wready (m_axil_wready),
    .m_axil_bresp (m_axil_bresp), .m_axil_bvalid (m_axil_bvalid), .m_axil_bready (m_axil_bready),
    .m_axil_araddr (m_axil_araddr), .m_axil_arprot (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid), .m_axil_arready (m_axil_arready),
    .m_axil_rdata (m_axil_rdata), .m_axil_rresp (m_axil_rresp),
    .m_axil_rvalid (m_axil_rvalid), .m_axil_rready (m_axil_rready)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Slave knobs and state
  int         ar_lat = 0, aw_lat = 0, w_lat = 0;
  int         ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  bit         ar_hold = 1'b0, r_hold = 1'b0;
  logic [1:0] rresp_val = 2'b00, bresp_val = 2'b00;
  bit         r_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] r_addr = '0;
  int         aw_beats = 0, w_beats = 0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A50000);
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    end else begin
      if (m_axil_rvalid && m_axil_rready) r_pend = 1'b0;
      if (m_axil_arvalid && m_axil_arready) begin r_pend = 1'b1; r_addr = m_axil_araddr; end
      if (m_axil_awvalid && m_axil_awready) begin aw_got = 1'b1; aw_beats++; end
      if (m_axil_wvalid && m_axil_wready) begin w_got = 1'b1; w_beats++; end
      if (m_axil_bvalid && m_axil_bready) b_pend = 1'b0;
      if (aw_got && w_got) begin b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0; end
    end
  end

  always @(negedge clk) begin
    m_axil_arready = m_axil_arvalid && !ar_hold && (ar_cnt >= ar_lat);
    ar_cnt = m_axil_arvalid ? ar_cnt + 1 : 0;
    m_axil_awready = m_axil_awvalid && (aw_cnt >= aw_lat);
    aw_cnt = m_axil_awvalid ? aw_cnt + 1 : 0;
    m_axil_wready = m_axil_wvalid && (w_cnt >= w_lat);
    w_cnt = m_axil_wvalid ? w_cnt + 1 : 0;
    m_axil_rvalid = r_pend && !r_hold;
    m_axil_rdata  = rd_model(r_addr);
    m_axil_rresp  = rresp_val;
    m_axil_bvalid = b_pend;
    m_axil_bresp  = bresp_val;
  end

  typedef struct {
    logic        wen;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        err;
  } rsp_t;
  rsp_t rsp_q[$];

  always @(negedge clk) begin
    if (rsp_valid) rsp_q.push_back('{rsp_wen, rsp_rdata, rsp_resp, rsp_err});
  end

  // Returns at the negedge just after the accepting clock edge.
  task automatic push(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = data; req_wstrb = strb;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_count", rsp_q.size(), n);
  endtask

  task automatic exp_rsp(input string tag, input logic wen, input logic [31:0] rdata,
                         input logic [1:0] resp);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      r = rsp_q.pop_front();
      chk({tag, "_wen"}, r.wen, wen);
      chk({tag, "_resp"}, r.resp, resp);
      chk({tag, "_err"}, r.err, resp[1]);
      if (!wen) chk({tag, "_rdata"}, r.rdata, rdata);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_valids", {m_axil_arvalid, m_axil_awvalid, m_axil_wvalid}, 3'b000);
    chk("rst_readies", {m_axil_rready, m_axil_bready}, 2'b00);
    chk("rst_rsp", {rsp_valid, rsp_wen, rsp_err, rsp_resp}, 5'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_addr", {m_axil_awaddr, m_axil_araddr}, 64'h0);
    rstn = 1'b1;

    // Single read of 0x100
    push(1'b0, 32'h100, 32'h0, 4'h0);
    chk("rd_lat_pre_arvalid", m_axil_arvalid, 1'b0);
    chk("rd_lat_pre_level", fifo_level, 3'd1);
    @(negedge clk);
    chk("rd_lat_arvalid", m_axil_arvalid, 1'b1);
    chk("rd_araddr", m_axil_araddr, 32'h100);
    wait_rsp(1);
    exp_rsp("rd100", 1'b0, 32'hDEADBEEF, 2'b00);
    repeat (3) @(negedge clk);
    chk("rd100_single_pulse", rsp_q.size(), 0);
    chk("rd100_idle", busy, 1'b0);

    // Write with W accepted three cycles before AW
    aw_lat = 3; w_lat = 0; aw_beats = 0; w_beats = 0;
    push(1'b1, 32'h200, 32'h12345678, 4'hF);
    @(negedge clk);
    chk("wr_payload", {m_axil_awaddr, m_axil_wdata}, 64'h00000200_12345678);
    chk("wr_strb", m_axil_wstrb, 4'hF);
    wait_rsp(1);
    exp_rsp("wr200", 1'b1, 32'h0, 2'b00);
    repeat (3) @(negedge clk);
    chk("wr_aw_beats", aw_beats, 1);
    chk("wr_w_beats", w_beats, 1);
    aw_lat = 0;

    // Fill the queue behind a stalled read, then one more request while full
    ar_hold = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b0, 32'h10 + 32'(4*i), 32'h0, 4'h0);
    chk("full_level", fifo_level, 3'd4);
    chk("full_req_ready", req_ready, 1'b0);
    chk("full_busy", busy, 1'b1);
    fork
      push(1'b1, 32'h40, 32'hCAFEF00D, 4'h3);
      begin
        repeat (4) @(negedge clk);
        chk("full_hold_level", fifo_level, 3'd4);
        ar_hold = 1'b0;
      end
    join
    wait_rsp(6);
    exp_rsp("ord0", 1'b0, 32'hA5A50010, 2'b00);
    exp_rsp("ord1", 1'b0, 32'hA5A50014, 2'b00);
    exp_rsp("ord2", 1'b0, 32'hA5A50018, 2'b00);
    exp_rsp("ord3", 1'b0, 32'hA5A5001C, 2'b00);
    exp_rsp("ord4", 1'b0, 32'hA5A50020, 2'b00);
    exp_rsp("ord5", 1'b1, 32'h0, 2'b00);

    // Read returning SLVERR, followed by a queued write
    ar_hold = 1'b1; rresp_val = 2'b10;
    push(1'b0, 32'h300, 32'h0, 4'h0);
    push(1'b1, 32'h304, 32'h55, 4'h1);
    ar_hold = 1'b0;
    wait_rsp(2);
    exp_rsp("rd_slverr", 1'b0, 32'hA5A50300, 2'b10);
    exp_rsp("wr_after_err", 1'b1, 32'h0, 2'b00);
    rresp_val = 2'b00;

    // Push coinciding with pop at level 2
    ar_hold = 1'b1;
    push(1'b0, 32'h50, 32'h0, 4'h0);
    push(1'b0, 32'h54, 32'h0, 4'h0);
    push(1'b0, 32'h58, 32'h0, 4'h0);
    chk("pp_level_pre", fifo_level, 3'd2);
    ar_hold = 1'b0;
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h5C;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pp_level_same", fifo_level, 3'd2);
    wait_rsp(4);
    exp_rsp("pp0", 1'b0, 32'hA5A50050, 2'b00);
    exp_rsp("pp1", 1'b0, 32'hA5A50054, 2'b00);
    exp_rsp("pp2", 1'b0, 32'hA5A50058, 2'b00);
    exp_rsp("pp3", 1'b0, 32'hA5A5005C, 2'b00);

    // Reset while waiting for read data with two entries queued
    r_hold = 1'b1;
    push(1'b0, 32'h60, 32'h0, 4'h0);
    push(1'b0, 32'h64, 32'h0, 4'h0);
    push(1'b0, 32'h68, 32'h0, 4'h0);
    k = 0;
    while (!m_axil_rready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_rst_in_rd_data", m_axil_rready, 1'b1);
    chk("mid_rst_level_pre", fifo_level, 3'd2);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_level", fifo_level, 3'd0);
    chk("mid_rst_arvalid", m_axil_arvalid, 1'b0);
    chk("mid_rst_rready", m_axil_rready, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    r_hold = 1'b0;
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_q.size(), 0);
    chk("mid_rst_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
